// File: rtl/myiram_loadable_if.sv
// Byte-streaming load port of the loadable instruction RAM.
// The master drives the program bytes and the RAM answers as the slave.
interface myiram_loadable_if #(
    parameter int DEPTH = 128
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             LD_START;
    logic [IDX_W-1:0] LD_BASE;
    logic             LD_VALID;
    logic [7:0]       LD_BYTE;
    logic             LD_LAST;
    logic             LD_READY;
    logic             LD_DONE;
    logic             LD_ERR;
    logic [CNT_W-1:0] LD_COUNT;

    modport master (
        output LD_START, LD_BASE, LD_VALID, LD_BYTE, LD_LAST,
        input  LD_READY, LD_DONE, LD_ERR, LD_COUNT
    );

    modport slave (
        input  LD_START, LD_BASE, LD_VALID, LD_BYTE, LD_LAST,
        output LD_READY, LD_DONE, LD_ERR, LD_COUNT
    );
endinterface

// File: rtl/myiram_loadable.sv
// Instruction RAM for the single-cycle CPU.
// Byte-addressed combinational fetch, program loaded at run time through a byte-stream port.
module myiram_loadable #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 128,
    parameter int BIG_ENDIAN     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Q,
    output logic              FETCH_VALID,
    output logic              MISALIGN,
    output logic              OOR,
    myiram_loadable_if.slave  ld
);
    localparam int BYTES   = DATA_W / 8;
    localparam int LANE_SH = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int LANE_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  clrPtr;
    logic [CNT_W-1:0]  wptr;
    logic [LANE_W-1:0] byteCnt;
    logic [DATA_W-1:0] wordBuf;
    logic [CNT_W-1:0]  ldCount;
    logic              ldErr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] fetchIdx;
    logic              accept;
    logic              wordFinal;
    logic              wantWrite;
    logic              overflow;
    logic              memWe;
    logic [LANE_W-1:0] laneSel;
    logic [DATA_W-1:0] nextWord;

    assign fetchIdx    = ADDR >> LANE_SH;
    assign MISALIGN    = |(ADDR & ADDR_W'(BYTES - 1));
    assign OOR         = 32'(fetchIdx) >= DEPTH;
    assign FETCH_VALID = (state == ST_IDLE);
    assign Q           = (FETCH_VALID && !OOR) ? mem[fetchIdx[IDX_W-1:0]] : '0;

    assign ld.LD_READY = (state == ST_LOAD);
    assign ld.LD_DONE  = (state == ST_DONE);
    assign ld.LD_ERR   = ldErr;
    assign ld.LD_COUNT = ldCount;

    // A partial word is flushed on LD_LAST; lanes not yet filled are still zero in wordBuf.
    assign accept    = ld.LD_VALID && (state == ST_LOAD);
    assign wordFinal = (32'(byteCnt) == BYTES - 1);
    assign wantWrite = accept && (wordFinal || ld.LD_LAST);
    assign overflow  = wantWrite && (32'(wptr) >= DEPTH);
    assign memWe     = wantWrite && !overflow;
    assign laneSel   = (BIG_ENDIAN != 0) ? (LANE_W'(BYTES - 1) - byteCnt) : byteCnt;

    always_comb begin
        nextWord = wordBuf;
        for (int i = 0; i < BYTES; i++) begin
            if (i == int'(laneSel)) begin
                nextWord[i*8 +: 8] = ld.LD_BYTE;
            end
        end
    end

    // Storage has no reset; the CLEAR sweep provides the zero-fill instead.
    always_ff @(posedge CLK) begin
        if (state == ST_CLEAR) begin
            mem[clrPtr] <= '0;
        end else if (memWe) begin
            mem[wptr[IDX_W-1:0]] <= nextWord;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clrPtr  <= '0;
            wptr    <= '0;
            byteCnt <= '0;
            wordBuf <= '0;
            ldCount <= '0;
            ldErr   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clrPtr <= clrPtr + 1'b1;
                    if (32'(clrPtr) == DEPTH - 1) begin
                        clrPtr <= '0;
                        state  <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (ld.LD_START) begin
                        state   <= ST_LOAD;
                        wptr    <= CNT_W'(ld.LD_BASE);
                        byteCnt <= '0;
                        wordBuf <= '0;
                        ldCount <= '0;
                        ldErr   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (overflow) begin
                        ldErr   <= 1'b1;
                        byteCnt <= '0;
                        wordBuf <= '0;
                        state   <= ST_DONE;
                    end else if (wantWrite) begin
                        wptr    <= wptr + 1'b1;
                        ldCount <= ldCount + 1'b1;
                        byteCnt <= '0;
                        wordBuf <= '0;
                        if (ld.LD_LAST) begin
                            state <= ST_DONE;
                        end
                    end else if (accept) begin
                        byteCnt <= byteCnt + 1'b1;
                        wordBuf <= nextWord;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_myiram_loadable.sv
// Directed bench for the loadable instruction RAM: a little-endian 128-word instance
// and a big-endian 64-word instance sharing clock, reset, address and byte stream.
module tb_myiram_loadable;
    logic        CLK;
    logic        RESET_N;
    logic [7:0]  addr;
    logic        ldStartLe;
    logic        ldStartBe;
    logic [6:0]  ldBase;
    logic        ldValid;
    logic [7:0]  ldByte;
    logic        ldLast;

    logic [15:0] qLe, qBe;
    logic        fvLe, fvBe, misLe, misBe, oorLe, oorBe;

    int testsRun    = 0;
    int testsFailed = 0;

    myiram_loadable_if #(.DEPTH(128)) ldLe ();
    myiram_loadable_if #(.DEPTH(64))  ldBe ();

    assign ldLe.LD_START = ldStartLe;
    assign ldLe.LD_BASE  = ldBase;
    assign ldLe.LD_VALID = ldValid;
    assign ldLe.LD_BYTE  = ldByte;
    assign ldLe.LD_LAST  = ldLast;
    assign ldBe.LD_START = ldStartBe;
    assign ldBe.LD_BASE  = ldBase[5:0];
    assign ldBe.LD_VALID = ldValid;
    assign ldBe.LD_BYTE  = ldByte;
    assign ldBe.LD_LAST  = ldLast;

    myiram_loadable #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .BIG_ENDIAN(0), .CLEAR_ON_RESET(1)) dutLe (
        .CLK(CLK), .RESET_N(RESET_N), .ADDR(addr), .Q(qLe),
        .FETCH_VALID(fvLe), .MISALIGN(misLe), .OOR(oorLe), .ld(ldLe)
    );

    myiram_loadable #(.DATA_W(16), .ADDR_W(8), .DEPTH(64), .BIG_ENDIAN(1), .CLEAR_ON_RESET(1)) dutBe (
        .CLK(CLK), .RESET_N(RESET_N), .ADDR(addr), .Q(qBe),
        .FETCH_VALID(fvBe), .MISALIGN(misBe), .OOR(oorBe), .ld(ldBe)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called on a falling edge; the byte is taken on the following rising edge.
    task automatic applyStimulus(input logic [7:0] b, input logic last);
        ldValid = 1'b1;
        ldByte  = b;
        ldLast  = last;
        @(negedge CLK);
        ldValid = 1'b0;
        ldLast  = 1'b0;
    endtask

    task automatic probe(input logic [7:0] a);
        addr = a;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        logic [15:0] acc;
        acc = '0;
        for (int a = 0; a < 256; a += 2) begin
            probe(8'(a));
            acc |= qLe;
        end
        checkOutput(tag, 32'(acc), 32'h0);
    endtask

    initial begin
        RESET_N   = 1'b0;
        addr      = 8'h00;
        ldStartLe = 1'b0;
        ldStartBe = 1'b0;
        ldBase    = 7'd0;
        ldValid   = 1'b0;
        ldByte    = 8'h00;
        ldLast    = 1'b0;

        #1;
        checkOutput("rst_fetch_valid", 32'(fvLe), 32'd0);
        checkOutput("rst_ld_ready", 32'(ldLe.LD_READY), 32'd0);
        checkOutput("rst_ld_done", 32'(ldLe.LD_DONE), 32'd0);
        checkOutput("rst_ld_err", 32'(ldLe.LD_ERR), 32'd0);
        checkOutput("rst_ld_count", 32'(ldLe.LD_COUNT), 32'd0);

        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;

        for (int c = 1; c <= 128; c++) begin
            @(negedge CLK);
            if (c == 63)  checkOutput("clear_be_busy", 32'(fvBe), 32'd0);
            if (c == 64)  checkOutput("clear_be_done", 32'(fvBe), 32'd1);
            if (c == 127) checkOutput("clear_le_busy", 32'(fvLe), 32'd0);
            if (c == 128) checkOutput("clear_le_done", 32'(fvLe), 32'd1);
        end
        checkAllZero("clear_all_zero");
        probe(8'hFE);
        checkOutput("clear_q_fe", 32'(qLe), 32'h0);

        // Big-endian instance: base word 5, two bytes.
        @(negedge CLK);
        ldBase    = 7'd5;
        ldStartBe = 1'b1;
        @(negedge CLK);
        ldStartBe = 1'b0;
        checkOutput("be_ready", 32'(ldBe.LD_READY), 32'd1);
        applyStimulus(8'h51, 1'b0);
        applyStimulus(8'h7F, 1'b1);
        checkOutput("be_done", 32'(ldBe.LD_DONE), 32'd1);
        checkOutput("be_count", 32'(ldBe.LD_COUNT), 32'd1);
        @(negedge CLK);
        probe(8'h0A);
        checkOutput("be_q_0a", 32'(qBe), 32'h517F);
        checkOutput("be_mis_0a", 32'(misBe), 32'd0);
        checkOutput("le_untouched_0a", 32'(qLe), 32'h0);
        probe(8'h0B);
        checkOutput("be_mis_0b", 32'(misBe), 32'd1);
        checkOutput("be_q_0b", 32'(qBe), 32'h517F);
        probe(8'h7E);
        checkOutput("be_oor_7e", 32'(oorBe), 32'd0);
        probe(8'h80);
        checkOutput("be_oor_80", 32'(oorBe), 32'd1);
        checkOutput("be_q_80", 32'(qBe), 32'h0);

        // Little-endian two-word program at base 0.
        @(negedge CLK);
        ldBase    = 7'd0;
        ldStartLe = 1'b1;
        @(negedge CLK);
        ldStartLe = 1'b0;
        checkOutput("load_ready", 32'(ldLe.LD_READY), 32'd1);
        checkOutput("load_fetch_gated", 32'(fvLe), 32'd0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'hF0, 1'b0);
        checkOutput("load_count_1", 32'(ldLe.LD_COUNT), 32'd1);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'hF4, 1'b1);
        checkOutput("load_done", 32'(ldLe.LD_DONE), 32'd1);
        checkOutput("load_done_ready", 32'(ldLe.LD_READY), 32'd0);
        checkOutput("load_count_2", 32'(ldLe.LD_COUNT), 32'd2);
        @(negedge CLK);
        checkOutput("load_done_pulse", 32'(ldLe.LD_DONE), 32'd0);
        checkOutput("load_fetch_back", 32'(fvLe), 32'd1);
        probe(8'h00);
        checkOutput("load_q_00", 32'(qLe), 32'hF001);
        probe(8'h02);
        checkOutput("load_q_02", 32'(qLe), 32'hF401);

        // Overflow from the last word: second word is dropped, no wrap to word 0.
        @(negedge CLK);
        ldBase    = 7'd127;
        ldStartLe = 1'b1;
        @(negedge CLK);
        ldStartLe = 1'b0;
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b1);
        checkOutput("ovf_err", 32'(ldLe.LD_ERR), 32'd1);
        checkOutput("ovf_count", 32'(ldLe.LD_COUNT), 32'd1);
        checkOutput("ovf_done", 32'(ldLe.LD_DONE), 32'd1);
        @(negedge CLK);
        probe(8'hFE);
        checkOutput("ovf_q_fe", 32'(qLe), 32'h2211);
        probe(8'h00);
        checkOutput("ovf_no_wrap", 32'(qLe), 32'hF001);
        checkOutput("ovf_err_sticky", 32'(ldLe.LD_ERR), 32'd1);

        // Odd byte count with LAST mid-word; a second LD_START inside LOAD must be ignored.
        @(negedge CLK);
        ldBase    = 7'h10;
        ldStartLe = 1'b1;
        @(negedge CLK);
        checkOutput("pad_err_cleared", 32'(ldLe.LD_ERR), 32'd0);
        ldBase = 7'h30;
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        ldStartLe = 1'b0;
        applyStimulus(8'hCC, 1'b1);
        checkOutput("pad_count", 32'(ldLe.LD_COUNT), 32'd2);
        @(negedge CLK);
        probe(8'h20);
        checkOutput("pad_q_20", 32'(qLe), 32'hBBAA);
        probe(8'h22);
        checkOutput("pad_q_22", 32'(qLe), 32'h00CC);
        probe(8'h60);
        checkOutput("pad_restart_ignored", 32'(qLe), 32'h0);

        // Reset in the middle of a session wipes everything.
        @(negedge CLK);
        ldBase    = 7'h40;
        ldStartLe = 1'b1;
        @(negedge CLK);
        ldStartLe = 1'b0;
        applyStimulus(8'h12, 1'b0);
        applyStimulus(8'h34, 1'b0);
        applyStimulus(8'h56, 1'b0);
        checkOutput("abort_in_load", 32'(ldLe.LD_READY), 32'd1);
        RESET_N = 1'b0;
        #1;
        checkOutput("abort_ready_low", 32'(ldLe.LD_READY), 32'd0);
        checkOutput("abort_fetch_low", 32'(fvLe), 32'd0);
        checkOutput("abort_count", 32'(ldLe.LD_COUNT), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (127) @(negedge CLK);
        checkOutput("abort_clearing", 32'(fvLe), 32'd0);
        @(negedge CLK);
        checkOutput("abort_cleared", 32'(fvLe), 32'd1);
        probe(8'h80);
        checkOutput("abort_q_80", 32'(qLe), 32'h0);
        probe(8'h00);
        checkOutput("abort_q_00", 32'(qLe), 32'h0);
        checkAllZero("abort_all_zero");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
